// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one-outstanding imem
// requests and presents pc / pc_next / inst through an output register plus skid.
module if_fetch_unit #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_id_write,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [PC_WIDTH-1:0]   pc_next,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  fetch_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;

  logic                  out_valid_q, out_valid_d;
  logic [PC_WIDTH-1:0]   out_pc_q, out_pc_d;
  logic [PC_WIDTH-1:0]   out_pc_next_q, out_pc_next_d;
  logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;

  logic                  skid_valid_q, skid_valid_d;
  logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [PC_WIDTH-1:0]   skid_pc_next_q, skid_pc_next_d;
  logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;

  logic                  consume;
  logic                  rsp_take;
  logic                  req_fire;
  logic [PC_WIDTH-1:0]   fetch_pc_inc;

  assign imem_req_valid = (state_q == S_REQ) && !redirect && !skid_valid_q;
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign consume        = out_valid_q && if_id_write;
  // Responses outside S_WAIT (squashed or illegal) are never captured.
  assign rsp_take       = (state_q == S_WAIT) && imem_rsp_valid && !redirect;
  assign fetch_pc_inc   = fetch_pc_q + PC_STEP;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_pc_next_d  = out_pc_next_q;
    out_inst_d     = out_inst_q;
    skid_valid_d   = skid_valid_q;
    skid_pc_d      = skid_pc_q;
    skid_pc_next_d = skid_pc_next_q;
    skid_inst_d    = skid_inst_q;

    if (redirect) begin
      fetch_pc_d   = redirect_pc;
      out_valid_d  = 1'b0;
      out_inst_d   = NOP_INST;
      skid_valid_d = 1'b0;
      case (state_q)
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ:   if (req_fire) state_d = S_WAIT;
        S_WAIT:  if (imem_rsp_valid) state_d = S_REQ;
        S_DROP:  if (imem_rsp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase

      if (rsp_take) fetch_pc_d = fetch_pc_inc;

      // Presentation order: output register, then skid, then the new response.
      if (!out_valid_q || consume) begin
        if (skid_valid_q) begin
          out_valid_d    = 1'b1;
          out_pc_d       = skid_pc_q;
          out_pc_next_d  = skid_pc_next_q;
          out_inst_d     = skid_inst_q;
          skid_valid_d   = rsp_take;
          skid_pc_d      = fetch_pc_q;
          skid_pc_next_d = fetch_pc_inc;
          skid_inst_d    = imem_rsp_data;
        end else if (rsp_take) begin
          out_valid_d   = 1'b1;
          out_pc_d      = fetch_pc_q;
          out_pc_next_d = fetch_pc_inc;
          out_inst_d    = imem_rsp_data;
        end else begin
          out_valid_d = 1'b0;
          out_inst_d  = NOP_INST;
        end
      end else if (rsp_take) begin
        skid_valid_d   = 1'b1;
        skid_pc_d      = fetch_pc_q;
        skid_pc_next_d = fetch_pc_inc;
        skid_inst_d    = imem_rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_REQ;
      fetch_pc_q     <= RESET_PC;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_pc_next_q  <= '0;
      out_inst_q     <= NOP_INST;
      skid_valid_q   <= 1'b0;
      skid_pc_q      <= '0;
      skid_pc_next_q <= '0;
      skid_inst_q    <= NOP_INST;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_pc_next_q  <= out_pc_next_d;
      out_inst_q     <= out_inst_d;
      skid_valid_q   <= skid_valid_d;
      skid_pc_q      <= skid_pc_d;
      skid_pc_next_q <= skid_pc_next_d;
      skid_inst_q    <= skid_inst_d;
    end
  end

  assign fetch_valid = out_valid_q;
  assign pc          = out_pc_q;
  assign pc_next     = out_pc_next_q;
  assign inst        = out_inst_q;

endmodule
